// File: rtl/mem_stage.sv
// MEM stage: word-organised data memory, store/load, writeback select, MEM/WB register.
// Optional `MEM_MISALIGN_EN: suppresses misaligned accesses and raises a sticky misalign_out flag.
module mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_1_in,
    input  logic [31:0] data_2_in,
    input  logic [4:0]  Rd_in,
    input  logic        MEM_wen_in,
    input  logic        WB_sel_in,
    input  logic        Reg_WB_in,
    input  logic        auipc_in,
    output logic [31:0] wb_data_out,
    output logic [4:0]  Rd_out,
    output logic        Reg_WB_out,
    output logic        oob_out,
    output logic        misalign_out,
    output logic [15:0] store_count_out
);

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              is_load;
    logic              is_store;
    logic              misaligned;
    logic              do_write;
    logic [31:0]       rd_word;
    logic [31:0]       wb_next;

    always_comb begin
        idx      = data_1_in[ADDR_W+1:2];
        in_range = (data_1_in[31:ADDR_W+2] == '0);
        is_store = MEM_wen_in;
        // Store wins over load; auipc always takes the ALU path.
        is_load  = WB_sel_in & ~auipc_in & ~MEM_wen_in;
`ifdef MEM_MISALIGN_EN
        misaligned = (is_load | is_store) & (data_1_in[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        do_write = is_store & in_range & ~misaligned & ~reset;
        rd_word  = mem[idx];

        wb_next = data_1_in;
        if (is_load) begin
            if (in_range && !misaligned) begin
                wb_next = rd_word;
            end else begin
                wb_next = '0;
            end
        end
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= data_2_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data_out     <= '0;
            Rd_out          <= '0;
            Reg_WB_out      <= 1'b0;
            oob_out         <= 1'b0;
            store_count_out <= '0;
        end else begin
            wb_data_out <= wb_next;
            Rd_out      <= Rd_in;
            Reg_WB_out  <= Reg_WB_in;
            oob_out     <= (is_load | is_store) & ~in_range;
            if (do_write) begin
                store_count_out <= store_count_out + 16'd1;
            end
        end
    end

`ifdef MEM_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_out <= 1'b0;
        end else if (misaligned) begin
            misalign_out <= 1'b1;
        end
    end
`else
    assign misalign_out = 1'b0;
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Owns the word-organised data memory: performs stores, performs synchronous loads, selects writeback data, and registers the MEM/WB outputs.
- Converts the byte address in data_1 to a word index internally, so upstream stages pass byte addresses unmodified.
- Sits between the EX/MEM register and the writeback mux / register file; also drives the MEM/WB forwarding taps for the hazard unit.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the data memory.
- ADDR_W, 8, word-index width; must equal log2(DEPTH_WORDS).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- data_1_in  input  32  ALU result / byte address (auipc result when auipc_in=1)
- data_2_in  input  32  store data (rs2)
- Rd_in  input  5  destination register
- MEM_wen_in  input  1  store request
- WB_sel_in  input  1  1 = writeback load data, 0 = writeback data_1_in
- Reg_WB_in  input  1  register write enable
- auipc_in  input  1  instruction is auipc; forces the ALU path
- wb_data_out  output  32  registered writeback data
- Rd_out  output  5  registered Rd
- Reg_WB_out  output  1  registered write enable
- oob_out  output  1  registered: this instruction's access was out of range
- misalign_out  output  1  sticky misaligned-access flag (see Optional Feature)
- store_count_out  output  16  number of committed stores since reset

Behaviour:
- Reset (when reset=1 at a clock edge): wb_data_out=0, Rd_out=0, Reg_WB_out=0, oob_out=0, misalign_out=0, store_count_out=0.
  - Memory array is not cleared.
  - A store presented in the reset cycle is suppressed.
- Word index = data_1_in[ADDR_W+1:2].
- In range ⇔ data_1_in[31:ADDR_W+2] == 0.
- is_load = WB_sel_in & ~auipc_in & ~MEM_wen_in.
- Store (MEM_wen_in=1, in range, not reset):
  - mem[index] <= data_2_in at the edge.
  - store_count_out increments by 1 and wraps at 0xFFFF → 0.
  - The store is never forwarded to wb_data_out.
- Out-of-range store: memory unchanged, counter unchanged, oob_out=1 on the next cycle.
- Latency: exactly 1 cycle. Inputs sampled at edge N are visible on all outputs after edge N; no stalls, no handshake; a new instruction is accepted every cycle.
- wb_data_out:
  - is_load & in range → mem[index] value before this edge's write.
  - is_load & out of range → 0, and oob_out=1.
  - Otherwise → data_1_in.
- auipc_in=1 always selects data_1_in, regardless of WB_sel_in.
- Store at edge N followed by a load of the same word at edge N+1 returns the new data (write completes at N).
- A single instruction cannot both load and store: MEM_wen_in=1 takes priority and is treated as a store.
- Rd_out and Reg_WB_out are registered unchanged; oob_out reflects only the current instruction.
- Bubble (all controls 0): passes data_1_in, Reg_WB_out=0, memory untouched.

Optional Feature:
- Macro: MEM_MISALIGN_EN.
- Defined:
  - A load or store with data_1_in[1:0] != 0 is misaligned.
  - Misaligned store: suppressed, not counted.
  - Misaligned load: writes back 0.
  - misalign_out is set sticky until reset.
- Undefined: data_1_in[1:0] are ignored (access truncates to the word) and misalign_out is tied 0.

Test Plan:
- Reset with MEM_wen_in=1, data_1_in=0x10, data_2_in=0xAA → after release all outputs 0, store_count_out=0; loading 0x10 does not return 0xAA unless written later.
- Store 0xDEADBEEF @0x08, then next cycle load @0x08 with Rd_in=5, Reg_WB_in=1 → one cycle later wb_data_out=0xDEADBEEF, Rd_out=5, Reg_WB_out=1, store_count_out=1.
- ALU op data_1_in=0x1234, WB_sel_in=0, Rd_in=7; also auipc_in=1 with WB_sel_in=1 → wb_data_out=0x1234 both cases, memory unchanged.
- Store @0x400 (DEPTH_WORDS=256) → oob_out=1, count unchanged, word 0 unchanged; load @0x400 → wb_data_out=0, oob_out=1.
- Back-to-back stores @0x00 ×65536 → store_count_out wraps to 0; last data readable at 0x00.
- MEM_MISALIGN_EN defined: store @0x06 suppressed, misalign_out=1 and stays 1; undefined: same store writes word 1, misalign_out=0.
